// File: rtl/datastore_buf.sv
// ----------------------------------------------------------------------------
// datastore_buf
//
// Purpose:
//   Character capture buffer between the PS/2 decode path and the cipher
//   engine. Characters are appended at an internal write pointer (the current
//   count). Backspace removes the last character. Clear aborts from any state.
//   A commit locks the buffer for the cipher, and a release empties it and
//   reopens capture. Every slot at or above count is held at zero, so the
//   flattened store doubles as the cipher's zero-padded message block.
//
// Ports:
//   i_clk           system clock, all state changes on the rising edge
//   i_resetn        asynchronous active-low reset
//   i_wr_valid      strobe: i_wr_data is a new character to append
//   i_wr_data       character to append
//   i_bksp          strobe: delete the last character
//   i_commit        strobe: message complete, lock for the cipher
//   i_release       strobe: cipher finished, empty buffer, reopen capture
//   i_clear         strobe: abort, empty buffer from any state
//   i_rd_index      random-access read address
//   o_rd_data       entry at i_rd_index (combinational), 0 when out of range
//   o_datastore_out flattened store, entry i at [DATA_W*i +: DATA_W]
//   o_count         number of valid entries, 0..DEPTH
//   o_full          count == DEPTH
//   o_empty         count == 0
//   o_locked        high while the buffer is locked for the cipher
//   o_overflow      sticky: a write was dropped because the buffer was full
// ----------------------------------------------------------------------------
module datastore_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 28,
   parameter int IDX_W  = 5
) (
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_wr_valid,
   input  logic [DATA_W-1:0]       i_wr_data,
   input  logic                    i_bksp,
   input  logic                    i_commit,
   input  logic                    i_release,
   input  logic                    i_clear,
   input  logic [IDX_W-1:0]        i_rd_index,
   output logic [DATA_W-1:0]       o_rd_data,
   output logic [DATA_W*DEPTH-1:0] o_datastore_out,
   output logic [IDX_W-1:0]        o_count,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_locked,
   output logic                    o_overflow
);

   localparam logic [IDX_W-1:0] LP_DEPTH = IDX_W'(DEPTH);
   localparam logic [IDX_W-1:0] LP_ONE   = IDX_W'(1);

   typedef enum logic {
      ST_CAPTURE = 1'b0,
      ST_LOCKED  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [IDX_W-1:0]    r_count;
   logic                r_overflow;

   logic                w_full;
   logic                w_empty;
   logic                w_do_clear;
   logic                w_do_bksp;
   logic                w_do_write;
   logic                w_set_overflow;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // State register.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= ST_CAPTURE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and action decode. Only strobes that mean something in the
   // current state take part in the priority chain: in CAPTURE that is
   // clear > commit > bksp > wr_valid (release is meaningless there), and in
   // LOCKED it is clear > release. A strobe that wins but whose guard fails
   // (e.g. bksp on an empty buffer) still swallows the lower strobes.
   always_comb begin
      w_next_state   = r_state;
      w_do_clear     = 1'b0;
      w_do_bksp      = 1'b0;
      w_do_write     = 1'b0;
      w_set_overflow = 1'b0;

      if (i_clear) begin
         w_do_clear   = 1'b1;
         w_next_state = ST_CAPTURE;
      end else begin
         case (r_state)
            ST_CAPTURE: begin
               if (i_commit) begin
                  if (!w_empty) begin
                     w_next_state = ST_LOCKED;
                  end
               end else if (i_bksp) begin
                  w_do_bksp = !w_empty;
               end else if (i_wr_valid) begin
                  w_do_write     = !w_full;
                  w_set_overflow = w_full;
               end
            end
            ST_LOCKED: begin
               if (i_release) begin
                  w_do_clear   = 1'b1;
                  w_next_state = ST_CAPTURE;
               end
            end
            default: begin
               w_next_state = ST_CAPTURE;
            end
         endcase
      end
   end

   // Register file, write pointer and sticky overflow. Backspace zeroes the
   // slot it vacates so that everything at or above count stays zero.
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_do_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_do_bksp) begin
         r_mem[r_count - LP_ONE] <= '0;
         r_count                 <= r_count - LP_ONE;
      end else if (w_do_write) begin
         r_mem[r_count] <= i_wr_data;
         r_count        <= r_count + LP_ONE;
      end else if (w_set_overflow) begin
         r_overflow <= 1'b1;
      end
   end

   // Random-access read port; addresses past the last entry read as zero.
   always_comb begin
      o_rd_data = '0;
      if (i_rd_index < LP_DEPTH) begin
         o_rd_data = r_mem[i_rd_index];
      end
   end

   // Flatten the register file for the cipher.
   always_comb begin
      o_datastore_out = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_datastore_out[DATA_W*i +: DATA_W] = r_mem[i];
      end
   end

   assign o_count    = r_count;
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_locked   = (r_state == ST_LOCKED);
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_datastore_buf.sv
// ----------------------------------------------------------------------------
// tb_datastore_buf
//
// Directed stimulus for datastore_buf. The stimulus process pushes expected
// values into a scoreboard queue after each operation. A separate monitor
// process drains the queue on every falling clock edge and compares each
// entry against the live DUT outputs.
// ----------------------------------------------------------------------------
module tb_datastore_buf;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 28;
   localparam int IDX_W  = 5;

   logic                    clk;
   logic                    resetn;
   logic                    wrValid;
   logic [DATA_W-1:0]       wrData;
   logic                    bksp;
   logic                    commit;
   logic                    rel;
   logic                    clr;
   logic [IDX_W-1:0]        rdIndex;
   logic [DATA_W-1:0]       rdData;
   logic [DATA_W*DEPTH-1:0] dsOut;
   logic [IDX_W-1:0]        count;
   logic                    full;
   logic                    empty;
   logic                    locked;
   logic                    overflow;

   typedef enum int {K_COUNT, K_FULL, K_EMPTY, K_LOCKED, K_OVF, K_RD, K_ENTRY, K_DS24, K_DSANY} kind_t;

   typedef struct {
      string       name;
      kind_t       kind;
      int          idx;
      logic [31:0] expv;
   } exp_t;

   exp_t sb[$];
   int   nChecks = 0;
   int   nPass   = 0;

   datastore_buf #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) dut (
      .i_clk          (clk),
      .i_resetn       (resetn),
      .i_wr_valid     (wrValid),
      .i_wr_data      (wrData),
      .i_bksp         (bksp),
      .i_commit       (commit),
      .i_release      (rel),
      .i_clear        (clr),
      .i_rd_index     (rdIndex),
      .o_rd_data      (rdData),
      .o_datastore_out(dsOut),
      .o_count        (count),
      .o_full         (full),
      .o_empty        (empty),
      .o_locked       (locked),
      .o_overflow     (overflow)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pull the observed value for one scoreboard entry out of the DUT outputs.
   function automatic logic [31:0] sampleDut(kind_t k, int idx);
      logic [31:0] v;
      v = '0;
      case (k)
         K_COUNT:  v = 32'(count);
         K_FULL:   v = 32'(full);
         K_EMPTY:  v = 32'(empty);
         K_LOCKED: v = 32'(locked);
         K_OVF:    v = 32'(overflow);
         K_RD:     v = 32'(rdData);
         K_ENTRY:  v = 32'(dsOut[DATA_W*idx +: DATA_W]);
         K_DS24:   v = 32'(dsOut[23:0]);
         K_DSANY:  v = 32'(|dsOut);
         default:  v = 32'hDEAD_BEEF;
      endcase
      return v;
   endfunction

   // Monitor: compare every queued expectation against the DUT on the
   // falling edge, well away from the active rising edge.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = sampleDut(e.kind, e.idx);
            nChecks++;
            if (act === e.expv) begin
               nPass++;
            end else begin
               $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.expv);
            end
         end
      end
   end

   // Queue an expectation for the monitor.
   task automatic checkOutput(input string name, input kind_t k, input int idx, input logic [31:0] expv);
      exp_t e;
      e.name = name;
      e.kind = k;
      e.idx  = idx;
      e.expv = expv;
      sb.push_back(e);
   endtask

   // Drive one cycle of strobes, let the rising edge consume them, then drop them.
   task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic bk,
                                input logic cm, input logic rl, input logic cl);
      @(negedge clk);
      #1;
      wrValid = wv;
      wrData  = wd;
      bksp    = bk;
      commit  = cm;
      rel     = rl;
      clr     = cl;
      @(posedge clk);
      #1;
      wrValid = 1'b0;
      wrData  = '0;
      bksp    = 1'b0;
      commit  = 1'b0;
      rel     = 1'b0;
      clr     = 1'b0;
   endtask

   task automatic writeByte(input logic [7:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doBksp();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doCommit();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic doRelease();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic doClear();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn  = 1'b0;
      wrValid = 1'b0;
      wrData  = '0;
      bksp    = 1'b0;
      commit  = 1'b0;
      rel     = 1'b0;
      clr     = 1'b0;
      rdIndex = '0;

      // Reset values.
      checkOutput("rst_count",  K_COUNT,  0, 32'd0);
      checkOutput("rst_empty",  K_EMPTY,  0, 32'd1);
      checkOutput("rst_full",   K_FULL,   0, 32'd0);
      checkOutput("rst_locked", K_LOCKED, 0, 32'd0);
      checkOutput("rst_ovf",    K_OVF,    0, 32'd0);
      checkOutput("rst_ds",     K_DSANY,  0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 resetn = 1'b1;

      // Basic append and read-back.
      rdIndex = 5'd1;
      writeByte(8'h41);
      writeByte(8'h42);
      writeByte(8'h43);
      checkOutput("abc_count",  K_COUNT,  0, 32'd3);
      checkOutput("abc_ds24",   K_DS24,   0, 32'h434241);
      checkOutput("abc_rd1",    K_RD,     0, 32'h42);
      checkOutput("abc_empty",  K_EMPTY,  0, 32'd0);
      checkOutput("abc_full",   K_FULL,   0, 32'd0);
      checkOutput("abc_locked", K_LOCKED, 0, 32'd0);

      // Fill to capacity, overflow, then backspace from full.
      doClear();
      checkOutput("clr_count", K_COUNT, 0, 32'd0);
      checkOutput("clr_ds",    K_DSANY, 0, 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         writeByte(8'(i));
      end
      checkOutput("fill_full",  K_FULL,  0, 32'd1);
      checkOutput("fill_count", K_COUNT, 0, 32'd28);
      checkOutput("fill_ovf",   K_OVF,   0, 32'd0);
      writeByte(8'h55);
      checkOutput("ovf_full",    K_FULL,  0,  32'd1);
      checkOutput("ovf_count",   K_COUNT, 0,  32'd28);
      checkOutput("ovf_flag",    K_OVF,   0,  32'd1);
      checkOutput("ovf_entry27", K_ENTRY, 27, 32'h1C);
      doBksp();
      checkOutput("bk_count",   K_COUNT, 0,  32'd27);
      checkOutput("bk_entry27", K_ENTRY, 27, 32'h00);
      checkOutput("bk_entry26", K_ENTRY, 26, 32'h1B);
      checkOutput("bk_full",    K_FULL,  0,  32'd0);
      checkOutput("bk_ovf",     K_OVF,   0,  32'd1);

      // Lock with overflow set; release must clear it.
      doCommit();
      checkOutput("lk27_locked", K_LOCKED, 0, 32'd1);
      doRelease();
      checkOutput("rel27_locked", K_LOCKED, 0, 32'd0);
      checkOutput("rel27_count",  K_COUNT,  0, 32'd0);
      checkOutput("rel27_ovf",    K_OVF,    0, 32'd0);
      checkOutput("rel27_ds",     K_DSANY,  0, 32'd0);

      // Empty buffer: bksp and commit are no-ops.
      doBksp();
      checkOutput("ebk_count", K_COUNT, 0, 32'd0);
      doCommit();
      checkOutput("ecm_locked", K_LOCKED, 0, 32'd0);
      checkOutput("ecm_count",  K_COUNT,  0, 32'd0);
      writeByte(8'h61);
      doCommit();
      writeByte(8'h62);
      doBksp();
      checkOutput("lkd_locked", K_LOCKED, 0, 32'd1);
      checkOutput("lkd_count",  K_COUNT,  0, 32'd1);
      checkOutput("lkd_entry0", K_ENTRY,  0, 32'h61);
      checkOutput("lkd_entry1", K_ENTRY,  1, 32'h00);

      // Locked with five characters, ignored write, release, reuse.
      doClear();
      checkOutput("clr2_locked", K_LOCKED, 0, 32'd0);
      for (int i = 0; i < 5; i++) begin
         writeByte(8'h20 + 8'(i));
      end
      doCommit();
      writeByte(8'h99);
      checkOutput("l5_locked", K_LOCKED, 0, 32'd1);
      checkOutput("l5_count",  K_COUNT,  0, 32'd5);
      checkOutput("l5_entry5", K_ENTRY,  5, 32'h00);
      checkOutput("l5_ovf",    K_OVF,    0, 32'd0);
      doRelease();
      checkOutput("r5_locked", K_LOCKED, 0, 32'd0);
      checkOutput("r5_count",  K_COUNT,  0, 32'd0);
      checkOutput("r5_ds",     K_DSANY,  0, 32'd0);
      checkOutput("r5_ovf",    K_OVF,    0, 32'd0);
      writeByte(8'h70);
      checkOutput("r5_entry0", K_ENTRY, 0, 32'h70);

      // Same-cycle strobe priority.
      doClear();
      writeByte(8'h11);
      writeByte(8'h22);
      applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("wb_count",  K_COUNT, 0, 32'd1);
      checkOutput("wb_entry1", K_ENTRY, 1, 32'h00);
      checkOutput("wb_entry0", K_ENTRY, 0, 32'h11);
      checkOutput("wb_ovf",    K_OVF,   0, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("cc_count",  K_COUNT,  0, 32'd0);
      checkOutput("cc_locked", K_LOCKED, 0, 32'd0);
      writeByte(8'h44);
      writeByte(8'h45);
      writeByte(8'h46);
      rdIndex = 5'd30;
      checkOutput("rd30", K_RD, 0, 32'h00);
      @(negedge clk);
      #1 rdIndex = 5'd2;
      checkOutput("rd2", K_RD, 0, 32'h46);

      // Asynchronous reset while locked with ten characters.
      doClear();
      for (int i = 0; i < 10; i++) begin
         writeByte(8'h80 + 8'(i));
      end
      doCommit();
      checkOutput("l10_locked", K_LOCKED, 0, 32'd1);
      checkOutput("l10_count",  K_COUNT,  0, 32'd10);
      @(posedge clk);
      #2 resetn = 1'b0;
      checkOutput("ar_count",  K_COUNT,  0, 32'd0);
      checkOutput("ar_locked", K_LOCKED, 0, 32'd0);
      checkOutput("ar_empty",  K_EMPTY,  0, 32'd1);
      checkOutput("ar_ds",     K_DSANY,  0, 32'd0);
      @(negedge clk);
      #1 resetn = 1'b1;
      writeByte(8'hA5);
      checkOutput("ar_entry0", K_ENTRY, 0, 32'hA5);
      checkOutput("ar_count1", K_COUNT, 0, 32'd1);

      // Let the monitor drain the queue, bounded.
      for (int w = 0; w < 10 && sb.size() > 0; w++) begin
         @(negedge clk);
      end
      #1;
      if (sb.size() > 0) begin
         $display("[TB] FAIL drain: got %0d pending checks, expected 0", sb.size());
         nChecks = nChecks + sb.size();
      end
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
